// File: rtl/rob_drain_sequencer_pkg.sv
// rtl/rob_drain_sequencer_pkg.sv - shared widths, ROB item layout, LoS codes and FSM states
package rob_drain_sequencer_pkg;

  localparam int ROW_W      = 11;
  localparam int COL_W      = 8;
  localparam int ITEM_W     = 24;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 64;

  localparam int ROB_ITEM_VLD_BIT      = 0;
  localparam int ROB_ITEM_COL_LSB      = 1;
  localparam int ROB_ITEM_COL_MSB      = 8;
  localparam int ROB_ITEM_LOS_LSB      = 9;
  localparam int ROB_ITEM_LOS_MSB      = 10;
  localparam int ROB_ITEM_SIZE_LSB     = 11;
  localparam int ROB_ITEM_SIZE_MSB     = 12;
  localparam int ROB_ITEM_USED_MSB     = 12;

  localparam logic [1:0] LOS_LOAD  = 2'b01;
  localparam logic [1:0] LOS_STORE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDREQ,
    ST_COLLECT,
    ST_FLUSH,
    ST_DONE
  } state_e;

  // Decoded FIFO entry: only what the command port needs survives decode.
  typedef struct packed {
    logic             wr;
    logic [COL_W-1:0] col;
    logic [1:0]       size;
  } cmd_entry_t;

  localparam int ENTRY_W = $bits(cmd_entry_t);

  function automatic logic los_legal(input logic [1:0] los);
    return (los == LOS_LOAD) || (los == LOS_STORE);
  endfunction

endpackage

// File: rtl/rob_drain_sequencer_fifo.sv
// rtl/rob_drain_sequencer_fifo.sv - synchronous FIFO with same-cycle push/pop
module sync_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  input  logic          i_pop,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_wr, w_rd;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_data  = r_mem[r_rptr];

  // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      if (w_rd) r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rob_drain_sequencer.sv
// rtl/rob_drain_sequencer.sv - drains one ROB row into DRAM column commands
module rob_drain_sequencer
  import rob_drain_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             iDrainReq,
  input  logic [ROW_W-1:0] iDrainRow,
  output logic             oDrainAck,
  output logic             oROB_Rd,
  output logic [ROW_W-1:0] oROB_Row,
  input  logic             iROB_ItemValid,
  input  logic [ITEM_W-1:0] iROB_Item,
  input  logic             iROB_ItemEnd,
  output logic             oCmdValid,
  input  logic             iCmdReady,
  output logic             oCmdWr,
  output logic [ROW_W-1:0] oCmdRow,
  output logic [COL_W-1:0] oCmdCol,
  output logic [1:0]       oCmdSize,
  output logic             oDrainDone,
  output logic [3:0]       oDrainCount,
  output logic             oErrTimeout,
  output logic             oErrOverflow,
  output logic             oErrLoS,
  output logic             oBusy
);

  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_e             r_state, w_next;
  logic [ROW_W-1:0]   r_row;
  logic [3:0]         r_count;
  logic [TMR_W-1:0]   r_timer;
  logic               r_err_timeout, r_err_overflow, r_err_los;

  logic               w_collect, w_issue, w_item_ok, w_legal;
  logic               w_push, w_pop, w_full, w_empty, w_cmd_valid;
  logic               w_end, w_timeout, w_accept;
  logic [1:0]         w_los;
  cmd_entry_t         w_push_entry, w_head;
  logic [ENTRY_W-1:0] w_push_data, w_head_data;
  logic               w_unused_item;

  assign w_unused_item = ^iROB_Item[ITEM_W-1:ROB_ITEM_USED_MSB+1];

  assign w_collect = (r_state == ST_COLLECT);
  assign w_issue   = w_collect || (r_state == ST_FLUSH);
  assign w_accept  = (r_state == ST_IDLE) && iDrainReq;

  assign w_los     = iROB_Item[ROB_ITEM_LOS_MSB:ROB_ITEM_LOS_LSB];
  assign w_legal   = los_legal(w_los);
  assign w_item_ok = w_collect && iROB_ItemValid && iROB_Item[ROB_ITEM_VLD_BIT];

  assign w_cmd_valid = w_issue && !w_empty;
  assign w_pop       = w_cmd_valid && iCmdReady;
  assign w_push      = w_item_ok && w_legal && (!w_full || w_pop);

  assign w_end     = w_collect && iROB_ItemEnd;
  assign w_timeout = w_collect && !iROB_ItemEnd && (r_timer == TMR_LAST);

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.wr   = (w_los == LOS_STORE);
    w_push_entry.col  = iROB_Item[ROB_ITEM_COL_MSB:ROB_ITEM_COL_LSB];
    w_push_entry.size = iROB_Item[ROB_ITEM_SIZE_MSB:ROB_ITEM_SIZE_LSB];
  end

  assign w_push_data = w_push_entry;
  assign w_head      = cmd_entry_t'(w_head_data);

  sync_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    oDrainAck   = 1'b0;
    oROB_Rd     = 1'b0;
    oROB_Row    = '0;
    oDrainDone  = 1'b0;
    oDrainCount = '0;
    oBusy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        oDrainAck = iDrainReq;
        if (iDrainReq) w_next = ST_RDREQ;
      end
      ST_RDREQ: begin
        oROB_Rd  = 1'b1;
        oROB_Row = r_row;
        w_next   = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (w_end || w_timeout) w_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_empty) w_next = ST_DONE;
      end
      ST_DONE: begin
        oDrainDone  = 1'b1;
        oDrainCount = r_count;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Command fields are forced to zero whenever no command is offered.
  assign oCmdValid = w_cmd_valid;
  assign oCmdWr    = w_cmd_valid & w_head.wr;
  assign oCmdRow   = w_cmd_valid ? r_row : '0;
  assign oCmdCol   = w_cmd_valid ? w_head.col : '0;
  assign oCmdSize  = w_cmd_valid ? w_head.size : '0;

  assign oErrTimeout  = r_err_timeout;
  assign oErrOverflow = r_err_overflow;
  assign oErrLoS      = r_err_los;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_row          <= '0;
      r_count        <= '0;
      r_timer        <= '0;
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_los      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_row   <= iDrainRow;
        r_count <= '0;
        r_timer <= '0;
      end else if (w_collect && !w_end && !w_timeout) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_pop && (r_count != 4'hF)) r_count <= r_count + 4'd1;
      if (w_timeout) r_err_timeout <= 1'b1;
      if (w_item_ok && w_legal && w_full && !w_pop) r_err_overflow <= 1'b1;
      if (w_item_ok && !w_legal) r_err_los <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rob_drain_sequencer.sv
// tb/tb_rob_drain_sequencer.sv - directed scoreboard bench for rob_drain_sequencer
module tb_rob_drain_sequencer;

  logic        clk, resetn;
  logic        iDrainReq;
  logic [10:0] iDrainRow;
  logic        oDrainAck, oROB_Rd;
  logic [10:0] oROB_Row;
  logic        iROB_ItemValid, iROB_ItemEnd;
  logic [23:0] iROB_Item;
  logic        oCmdValid, iCmdReady, oCmdWr;
  logic [10:0] oCmdRow;
  logic [7:0]  oCmdCol;
  logic [1:0]  oCmdSize;
  logic        oDrainDone;
  logic [3:0]  oDrainCount;
  logic        oErrTimeout, oErrOverflow, oErrLoS, oBusy;

  typedef struct {
    logic        wr;
    logic [10:0] row;
    logic [7:0]  col;
    logic [1:0]  size;
  } exp_cmd_t;

  exp_cmd_t    exp_q[$];
  int          exp_done[$];
  int          checks = 0;
  int          errors = 0;
  logic [10:0] cur_row;

  rob_drain_sequencer dut (
    .clk(clk), .resetn(resetn),
    .iDrainReq(iDrainReq), .iDrainRow(iDrainRow), .oDrainAck(oDrainAck),
    .oROB_Rd(oROB_Rd), .oROB_Row(oROB_Row),
    .iROB_ItemValid(iROB_ItemValid), .iROB_Item(iROB_Item), .iROB_ItemEnd(iROB_ItemEnd),
    .oCmdValid(oCmdValid), .iCmdReady(iCmdReady), .oCmdWr(oCmdWr),
    .oCmdRow(oCmdRow), .oCmdCol(oCmdCol), .oCmdSize(oCmdSize),
    .oDrainDone(oDrainDone), .oDrainCount(oDrainCount),
    .oErrTimeout(oErrTimeout), .oErrOverflow(oErrOverflow), .oErrLoS(oErrLoS),
    .oBusy(oBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted command and every drain completion is scored here.
  always @(negedge clk) begin
    if (resetn && oCmdValid && iCmdReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cmd_unexpected actual col=%0h required=none", oCmdCol);
      end else begin
        exp_cmd_t e;
        e = exp_q.pop_front();
        chk("cmd_wr",   32'(oCmdWr),   32'(e.wr));
        chk("cmd_row",  32'(oCmdRow),  32'(e.row));
        chk("cmd_col",  32'(oCmdCol),  32'(e.col));
        chk("cmd_size", 32'(oCmdSize), 32'(e.size));
      end
    end
    if (resetn && oDrainDone) begin
      if (exp_done.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual count=%0d required=none", oDrainCount);
      end else begin
        chk("drain_count", 32'(oDrainCount), 32'(exp_done.pop_front()));
      end
    end
  end

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},     32'(oBusy),        0);
    chk({tag, "_cmdvalid"}, 32'(oCmdValid),    0);
    chk({tag, "_cmdcol"},   32'(oCmdCol),      0);
    chk({tag, "_robrd"},    32'(oROB_Rd),      0);
    chk({tag, "_robrow"},   32'(oROB_Row),     0);
    chk({tag, "_done"},     32'(oDrainDone),   0);
    chk({tag, "_count"},    32'(oDrainCount),  0);
    chk({tag, "_errto"},    32'(oErrTimeout),  0);
    chk({tag, "_errov"},    32'(oErrOverflow), 0);
    chk({tag, "_errlos"},   32'(oErrLoS),      0);
  endtask

  // Returns at posedge+1 of the first COLLECT cycle.
  task automatic drain(input logic [10:0] row, input int exp_cnt);
    bit got;
    got = 0;
    cur_row = row;
    exp_done.push_back(exp_cnt);
    iDrainReq = 1'b1;
    iDrainRow = row;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (oDrainAck) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL drain_ack actual=0 required=1");
    end
    tick();
    iDrainReq = 1'b0;
    @(negedge clk);
    chk("rob_rd",  32'(oROB_Rd),  1);
    chk("rob_row", 32'(oROB_Row), 32'(row));
    tick();
  endtask

  task automatic drive_item(input logic vld, input logic [7:0] col, input logic [1:0] los,
                            input logic [1:0] size, input logic last, input logic expect_cmd);
    exp_cmd_t e;
    iROB_ItemValid = 1'b1;
    iROB_Item      = {6'h00, col[6:2], size, los, col, vld};
    iROB_ItemEnd   = last;
    if (expect_cmd) begin
      e.wr = (los == 2'b10); e.row = cur_row; e.col = col; e.size = size;
      exp_q.push_back(e);
    end
    tick();
    iROB_ItemValid = 1'b0;
    iROB_ItemEnd   = 1'b0;
    iROB_Item      = '0;
  endtask

  task automatic wait_done();
    bit got;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (oDrainDone) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_wait actual=none required=oDrainDone");
    end
    tick();
  endtask

  initial begin
    int d;
    resetn = 1'b0; iDrainReq = 1'b0; iDrainRow = '0;
    iROB_ItemValid = 1'b0; iROB_Item = '0; iROB_ItemEnd = 1'b0; iCmdReady = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    tick();
    resetn = 1'b1;
    tick();

    // Basic drain: three loads
    iCmdReady = 1'b1;
    drain(11'h155, 3);
    drive_item(1, 8'h10, 2'b01, 2'd2, 0, 1);
    chk("cmd_latency", 32'(oCmdValid), 1);
    drive_item(1, 8'h20, 2'b01, 2'd2, 0, 1);
    drive_item(1, 8'h30, 2'b01, 2'd2, 1, 1);
    wait_done();

    // Back-pressure with a store then a load
    iCmdReady = 1'b0;
    drain(11'h2AA, 2);
    drive_item(1, 8'h05, 2'b10, 2'd1, 0, 1);
    drive_item(1, 8'h06, 2'b01, 2'd3, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(oCmdValid), 1);
      chk("bp_col",   32'(oCmdCol),   32'h05);
      chk("bp_wr",    32'(oCmdWr),    1);
      chk("bp_size",  32'(oCmdSize),  1);
    end
    tick();
    iCmdReady = 1'b1;
    wait_done();

    // Overflow: nine items into an eight-deep buffer
    iCmdReady = 1'b0;
    drain(11'h0F0, 8);
    for (int i = 1; i <= 9; i++)
      drive_item(1, 8'(i), 2'b01, 2'd0, (i == 9), (i <= 8));
    chk("ovf_flag", 32'(oErrOverflow), 1);
    chk("ovf_los_clean", 32'(oErrLoS), 0);
    chk("ovf_to_clean", 32'(oErrTimeout), 0);
    iCmdReady = 1'b1;
    wait_done();

    // Timeout: no ItemEnd after the ROB read
    drain(11'h003, 0);
    d = 0;
    for (int i = 1; i <= 100 && d == 0; i++) begin
      @(negedge clk);
      if (i == 40) chk("to_not_early", 32'(oErrTimeout), 0);
      if (oDrainDone) d = i;
    end
    chk("to_done_window", 32'((d >= 64) && (d <= 68)), 1);
    chk("to_flag", 32'(oErrTimeout), 1);
    tick();
    drain(11'h007, 1);
    drive_item(1, 8'h44, 2'b01, 2'd1, 1, 1);
    wait_done();

    // Filtering: invalid entry, illegal LoS, one good load
    chk("los_clean", 32'(oErrLoS), 0);
    drain(11'h0AB, 1);
    drive_item(0, 8'h11, 2'b01, 2'd0, 0, 0);
    drive_item(1, 8'h22, 2'b11, 2'd0, 0, 0);
    drive_item(1, 8'h7F, 2'b01, 2'd2, 1, 1);
    wait_done();
    chk("los_flag", 32'(oErrLoS), 1);

    // Reset in the middle of a drain with two items buffered
    iCmdReady = 1'b0;
    drain(11'h155, 0);
    drive_item(1, 8'h0A, 2'b01, 2'd0, 0, 1);
    drive_item(1, 8'h0B, 2'b10, 2'd0, 0, 1);
    chk("rst_pre_valid", 32'(oCmdValid), 1);
    resetn = 1'b0;
    exp_q.delete();
    exp_done.delete();
    #1;
    chk_idle_outputs("midrst");
    tick();
    resetn = 1'b1;
    iCmdReady = 1'b1;
    tick();
    drain(11'h001, 1);
    drive_item(1, 8'h55, 2'b10, 2'd3, 1, 1);
    wait_done();

    repeat (4) tick();
    chk("exp_cmd_left", 32'(exp_q.size()), 0);
    chk("exp_done_left", 32'(exp_done.size()), 0);
    chk("final_busy", 32'(oBusy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
